sr_latch: RTL and testbench
===========================

# sr_latch

Clocked set/reset storage bank. Each of `WIDTH` independent bits is set, reset, or held on the rising clock edge according to its S/R input pair. A complementary output is kept for every bit. The S=R=1 input combination has a defined, parameter-selected resolution and is flagged so that upstream control logic can detect illegal requests. The block is a leaf primitive used wherever control flags need set/clear semantics.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent SR bits.
- `BOTH_MODE`, default 0: resolution when s=r=1. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- `ERR_CNT_W`, default 8: width of the illegal-request counter.

Ports:
- `clk`, input, 1: clock. All state updates occur on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `s`, input, WIDTH: per-bit set request.
- `r`, input, WIDTH: per-bit reset request.
- `q`, output, WIDTH: stored state.
- `q_n`, output, WIDTH: complement of `q`.
- `both`, output, 1: registered flag, high for one cycle after any edge where some bit had s=r=1.
- `err_cnt`, output, ERR_CNT_W: saturating count of edges on which `both` was asserted.

## Operation
- Per bit i on the rising edge of `clk`, when `rst`=0:
  - s=0, r=0: q[i] holds.
  - s=0, r=1: q[i] becomes 0.
  - s=1, r=0: q[i] becomes 1.
  - s=1, r=1: resolved per `BOTH_MODE`.
- `q_n` equals `~q` at all times. It is never independently stored, so q and q_n can never be equal.
- `both` is registered as the OR over all bits of (s[i] & r[i]) sampled at the edge.
- `err_cnt` increments by 1 on each edge where any bit has s=r=1. It saturates at 2^ERR_CNT_W−1 and does not wrap.
- Bits are fully independent. Mixed commands in one cycle (some bits set, some reset, some both) are all applied on the same edge.
- Inputs are sampled only at the rising edge. Input changes between edges have no effect on q (edge-triggered, not transparent).

## Timing
- Latency: q reflects s/r one edge after sampling, visible immediately after the rising edge. There is no combinational path from s or r to any output.
- Reset, when `rst`=1 regardless of clock: q=0, q_n=all ones, both=0, err_cnt=0.
- If reset is asserted mid-operation, it overrides any pending edge. While reset is held, s and r are ignored.
- Reset release: the first edge with `rst`=0 applies s/r normally.
- If `rst` deasserts coincident with a clock edge, that edge is ignored. The next edge is the first active one.
- Toggle mode (`BOTH_MODE`=3): q[i] inverts on every edge while s=r=1 is held.

## Test plan
- Reset: assert rst with s=r=0 → q=0, q_n=1, both=0, err_cnt=0 asynchronously, with no clock required.
- Hold/reset/set sequence (WIDTH=1, BOTH_MODE=0), one edge each:
  - s=0, r=0 → q=0, q_n=1.
  - s=0, r=1 → q=0, q_n=1.
  - s=1, r=0 → q=1, q_n=0.
  - s=0, r=0 → q stays 1.
- Both-high resolution: from q=1, apply s=r=1 for one edge.
  - Mode 0 → q=1.
  - Mode 1 → q=1.
  - Mode 2 → q=0.
  - Mode 3 → q=0; a second edge gives q=1.
  - In every mode, both=1 for one cycle and err_cnt=1.
- Edge sensitivity: pulse s=1 between edges, returning to 0 before the rising edge → q unchanged.
- Multi-bit, WIDTH=4: from q=4'b0000, apply s=4'b1010, r=4'b0110 with BOTH_MODE=1 → q=4'b1010, q_n=4'b0101, both=1. Then apply s=0, r=4'b1111 → q=4'b0000, both=0.
- Saturation and reset (ERR_CNT_W=2): hold s=r=1 for 5 edges → err_cnt=3. Assert rst asynchronously mid-cycle → err_cnt=0 and q=0 immediately.

Source files
------------

// File: rtl/sr_latch.sv
// Clocked bank of independent set/reset bits with a complementary output,
// a registered s=r=1 flag and a saturating count of illegal requests.
module sr_latch #(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s,
  input  logic [WIDTH-1:0]     r,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_n,
  output logic                 both,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0]     q_q, q_d;
  logic                 both_q, both_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) return v;
    return v + ERR_CNT_W'(1);
  endfunction

  function automatic logic resolve_both(input logic cur);
    case (BOTH_MODE)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return ~cur;
      default: return cur;
    endcase
  endfunction

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = resolve_both(q_q[i]);
        default: q_d[i] = q_q[i];
      endcase
    end
    both_d = |(s & r);
    cnt_d  = both_d ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      both_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      both_q <= both_d;
      cnt_q  <= cnt_d;
    end
  end

  // q_n is derived, never stored, so it cannot disagree with q.
  assign q       = q_q;
  assign q_n     = ~q_q;
  assign both    = both_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch: all four s=r=1 resolutions, a 4-bit bank
// and a 2-bit saturating error counter, sharing one clock and reset.
module tb_sr_latch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // single-bit instances, one per BOTH_MODE, sharing stimulus
  logic       s1, r1;
  logic       q_m   [4];
  logic       qn_m  [4];
  logic       both_m[4];
  logic [7:0] cnt_m [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_latch #(.WIDTH(1), .BOTH_MODE(g), .ERR_CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(q_m[g]), .q_n(qn_m[g]), .both(both_m[g]), .err_cnt(cnt_m[g])
    );
  end

  logic [3:0] s4, r4, q4, qn4;
  logic       both4;
  logic [7:0] cnt4;
  sr_latch #(.WIDTH(4), .BOTH_MODE(1), .ERR_CNT_W(8)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4),
    .q(q4), .q_n(qn4), .both(both4), .err_cnt(cnt4)
  );

  logic       ss, rs, qs, qns, boths;
  logic [1:0] cnts;
  sr_latch #(.WIDTH(1), .BOTH_MODE(0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .s(ss), .r(rs),
    .q(qs), .q_n(qns), .both(boths), .err_cnt(cnts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; s1 = 0; r1 = 0; s4 = '0; r4 = '0; ss = 0; rs = 0;
    #2;  // before the first clock edge
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rst_q_m%0d", m),    q_m[m],    0);
      check($sformatf("rst_qn_m%0d", m),   qn_m[m],   1);
      check($sformatf("rst_both_m%0d", m), both_m[m], 0);
      check($sformatf("rst_cnt_m%0d", m),  cnt_m[m],  0);
    end
    check("rst_q4",  q4,  4'h0);
    check("rst_qn4", qn4, 4'hF);
    step();
    @(negedge clk);
    rst = 1'b0;

    s1 = 0; r1 = 0; step();
    check("hold0_q", q_m[0], 0); check("hold0_qn", qn_m[0], 1);
    s1 = 0; r1 = 1; step();
    check("rst_q", q_m[0], 0); check("rst_qn", qn_m[0], 1);
    s1 = 1; r1 = 0; step();
    check("set_q", q_m[0], 1); check("set_qn", qn_m[0], 0);
    s1 = 0; r1 = 0; step();
    check("hold1_q", q_m[0], 1); check("hold1_qn", qn_m[0], 0);
    check("hold1_both", both_m[0], 0);

    s1 = 1; r1 = 1; step();
    check("both_q_m0", q_m[0], 1);
    check("both_q_m1", q_m[1], 1);
    check("both_q_m2", q_m[2], 0);
    check("both_q_m3", q_m[3], 0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("both_flag_m%0d", m), both_m[m], 1);
      check($sformatf("both_cnt_m%0d", m),  cnt_m[m],  1);
      check($sformatf("both_qn_m%0d", m),   qn_m[m],   {31'b0, ~q_m[m]});
    end
    step();
    check("toggle2_q_m3", q_m[3], 1);
    check("toggle2_cnt_m3", cnt_m[3], 2);
    s1 = 0; r1 = 0; step();
    check("both_clr_m0", both_m[0], 0);
    check("cnt_keep_m0", cnt_m[0], 2);

    // reset pulse between edges must not reach q
    #2 r1 = 1;
    #1 check("pulse_mid_q", q_m[0], 1);
    #1 r1 = 0;
    step();
    check("pulse_q", q_m[0], 1);
    check("pulse_both", both_m[0], 0);

    s4 = 4'b1010; r4 = 4'b0110; step();
    check("w4_q", q4, 4'b1010); check("w4_qn", qn4, 4'b0101); check("w4_both", both4, 1);
    s4 = 4'b0000; r4 = 4'b1111; step();
    check("w4_clr_q", q4, 4'b0000); check("w4_clr_both", both4, 0);
    check("w4_cnt", cnt4, 1);

    ss = 1; rs = 0; step();
    check("sat_set_q", qs, 1);
    ss = 1; rs = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("sat_cnt_%0d", k), cnts, (k > 3) ? 3 : k);
    end
    check("sat_q_hold", qs, 1);
    #2 rst = 1'b1;
    #1;
    check("async_cnt", cnts, 0);
    check("async_q", qs, 0);
    check("async_qn", qns, 1);
    check("async_both", boths, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
